gelu_lut_sequencer: RTL and testbench

Streaming controller that drives the dual-port GELU lookup ROM (96 entries, Q1.15 phi values, 1-cycle registered read, read-enable hold) and turns it into a GELU unit.
- Per accepted sample x it issues one paired ROM read of entries i and i+1 on ports A/B, linearly interpolates phi(x), and outputs y = x·phi(x).
- A frame FSM processes cfg_len samples per start command.
- It sits between the SFU input stream and the SFU output stream.

---
 rtl/gelu_lut_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_gelu_lut_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gelu_lut_sequencer.sv
// Streaming GELU unit: paired reads of a phi lookup ROM, linear interpolation
// and y = x*phi(x), sequenced per frame by an IDLE/RUN/DRAIN controller.
//
// state | meaning
// IDLE  | waiting for start; no input accepted
// RUN   | accepting samples until len have been taken
// DRAIN | input closed; pipeline flushing until the last output handshake
module gelu_lut_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int LUT_DEPTH  = 96,
    parameter int FRAC_BITS  = 8,
    parameter int BIAS       = 0,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr_a,
    output logic [ADDR_WIDTH-1:0] rom_addr_b,
    input  logic [DATA_WIDTH-1:0] rom_q_a,
    input  logic [DATA_WIDTH-1:0] rom_q_b
);

    localparam int POS_W    = DATA_WIDTH + 2;
    localparam int PHI_FRAC = DATA_WIDTH - 1;
    localparam logic signed [POS_W-1:0] POS_MAX = POS_W'((LUT_DEPTH - 1) << FRAC_BITS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(LUT_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
    logic [LEN_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic                 done_q, done_d;

    logic advance;
    logic accept;
    logic out_hs;
    logic in_ready_w;

    // S0 position decode
    logic signed [POS_W-1:0] pos;
    logic                    below;
    logic                    above;
    logic [ADDR_WIDTH-1:0]   addr_a;
    logic [ADDR_WIDTH-1:0]   addr_b;
    logic [FRAC_BITS-1:0]    frac;

    // S1: ROM data is live on rom_q_*, aligned with these registers
    logic                    s1_valid_q;
    logic [DATA_WIDTH-1:0]   s1_x_q;
    logic [FRAC_BITS-1:0]    s1_frac_q;
    logic                    s1_below_q;

    logic signed [DATA_WIDTH:0]             diff;
    logic signed [DATA_WIDTH+FRAC_BITS+1:0] prod;
    logic [DATA_WIDTH-1:0]                  phi_d;

    // S2
    logic                    s2_valid_q;
    logic [DATA_WIDTH-1:0]   s2_x_q;
    logic [DATA_WIDTH-1:0]   s2_phi_q;

    logic signed [2*DATA_WIDTH:0] y_prod;
    logic [DATA_WIDTH-1:0]        y_d;

    // S3
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;

    assign advance    = !out_valid_q || out_ready;
    assign out_hs     = out_valid_q && out_ready;
    assign in_ready_w = (state_q == ST_RUN) && advance && (acc_cnt_q < len_q);
    assign accept     = in_valid && in_ready_w;

    always_comb begin
        pos    = POS_W'($signed(in_data)) + POS_W'(BIAS);
        below  = pos[POS_W-1];
        above  = !below && (pos >= POS_MAX);
        addr_a = '0;
        addr_b = '0;
        frac   = '0;
        if (above) begin
            addr_a = ADDR_LAST;
            addr_b = ADDR_LAST;
        end else if (!below) begin
            addr_a = ADDR_WIDTH'(pos >>> FRAC_BITS);
            addr_b = addr_a + ADDR_WIDTH'(1);
            frac   = FRAC_BITS'(pos);
        end
    end

    // Addresses only leave the block on an accept so idle cycles read entry 0
    assign rom_addr_a = accept ? addr_a : '0;
    assign rom_addr_b = accept ? addr_b : '0;
    assign rom_en     = advance && (state_q != ST_IDLE);

    always_comb begin
        diff  = $signed({1'b0, rom_q_b}) - $signed({1'b0, rom_q_a});
        prod  = diff * $signed({1'b0, s1_frac_q});
        phi_d = s1_below_q ? '0 : rom_q_a + DATA_WIDTH'(prod >>> FRAC_BITS);
    end

    always_comb begin
        y_prod = $signed(s2_x_q) * $signed({1'b0, s2_phi_q});
        y_d    = DATA_WIDTH'(y_prod >>> PHI_FRAC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_frac_q   <= '0;
            s1_below_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_x_q      <= '0;
            s2_phi_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (advance) begin
            s1_valid_q  <= accept;
            s1_x_q      <= in_data;
            s1_frac_q   <= frac;
            s1_below_q  <= below;
            s2_valid_q  <= s1_valid_q;
            s2_x_q      <= s1_x_q;
            s2_phi_q    <= phi_d;
            out_valid_q <= s2_valid_q;
            out_data_q  <= y_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        acc_cnt_d = acc_cnt_q;
        out_cnt_d = out_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        len_d     = cfg_len;
                        acc_cnt_d = '0;
                        out_cnt_d = '0;
                        state_d   = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + LEN_WIDTH'(1);
                    if (acc_cnt_d == len_q) state_d = ST_DRAIN;
                end
                if (out_hs) out_cnt_d = out_cnt_q + LEN_WIDTH'(1);
            end
            ST_DRAIN: begin
                if (out_hs) begin
                    out_cnt_d = out_cnt_q + LEN_WIDTH'(1);
                    if (out_cnt_q == len_q - LEN_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            acc_cnt_q <= '0;
            out_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            acc_cnt_q <= acc_cnt_d;
            out_cnt_q <= out_cnt_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign in_ready  = in_ready_w;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    // out_cnt only moves on a handshake, so this is stable through stalls
    assign out_last  = out_valid_q && (out_cnt_q == len_q - LEN_WIDTH'(1));

endmodule

// File: tb/tb_gelu_lut_sequencer.sv
// Directed bench for gelu_lut_sequencer with a behavioural phi ROM and a
// scoreboard of expected outputs built from an independent arithmetic model.
module tb_gelu_lut_sequencer;

    localparam int DW = 16;
    localparam int AW = 7;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic          busy, done;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          rom_en;
    logic [AW-1:0] rom_addr_a, rom_addr_b;
    logic [DW-1:0] rom_q_a = '0;
    logic [DW-1:0] rom_q_b = '0;

    gelu_lut_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_len    (cfg_len),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .rom_en     (rom_en),
        .rom_addr_a (rom_addr_a),
        .rom_addr_b (rom_addr_b),
        .rom_q_a    (rom_q_a),
        .rom_q_b    (rom_q_b)
    );

    always #5 clk = ~clk;

    logic [15:0] lut [96];
    logic [15:0] xs [16];

    // Registered-read ROM that holds its output while disabled
    always @(posedge clk) begin
        if (rom_en) begin
            rom_q_a <= lut[rom_addr_a];
            rom_q_b <= lut[rom_addr_b];
        end
    end

    typedef struct {
        logic [15:0] y;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int model_phi(input logic [15:0] x);
        int pos, i, f, d;
        pos = int'($signed(x));
        if (pos < 0) return 0;
        if (pos >= 95 * 256) return int'(lut[95]);
        i = pos / 256;
        f = pos % 256;
        d = int'(lut[i+1]) - int'(lut[i]);
        return int'(lut[i]) + ((d * f) >>> 8);
    endfunction

    function automatic logic [15:0] model_y(input logic [15:0] x);
        int prod;
        prod = int'($signed(x)) * model_phi(x);
        return 16'(prod >>> 15);
    endfunction

    function automatic logic [6:0] model_addr(input logic [15:0] x, input bit second);
        int pos;
        pos = int'($signed(x));
        if (pos < 0) return 7'd0;
        if (pos >= 95 * 256) return 7'd95;
        return 7'(pos / 256 + (second ? 1 : 0));
    endfunction

    // ready_mode: 0 always ready, 1 toggle 1-0-1, 2 random
    task automatic run_frame(input int len, input int ready_mode, input bit chk_lat,
                             input int start_at, input int stop_after,
                             input bit use_lit, input logic [15:0] lit_y);
        int          idx = 0;
        int          outs = 0;
        int          cyc = 0;
        bit          fin = 1'b0;
        bit          hold_v = 1'b0;
        logic [15:0] hold_d = '0;
        logic        hold_l = 1'b0;
        exp_t        e;
        cfg_len = LW'(len);
        start = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_len = 16'd3;
        chk("busy_run", busy, 1);
        while (!fin && cyc < 400) begin
            in_valid = (idx < len);
            in_data = xs[idx % 16];
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = (cyc == start_at);
            if (start) cfg_len = 16'd5;
            @(negedge clk);
            if (out_valid && hold_v) begin
                chk("hold_data", out_data, hold_d);
                chk("hold_last", out_last, hold_l);
            end
            if (out_valid && !out_ready) chk("rom_en_stall", rom_en, 0);
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
            if (in_valid && in_ready) begin
                chk("addr_a", rom_addr_a, model_addr(in_data, 1'b0));
                chk("addr_b", rom_addr_b, model_addr(in_data, 1'b1));
                e.y = use_lit ? lit_y : model_y(in_data);
                e.last = (idx == len - 1);
                e.cyc = cyc;
                sb.push_back(e);
                idx++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    chk("y", out_data, e.y);
                    chk("last", out_last, e.last);
                    if (chk_lat) chk("latency", cyc - e.cyc, 3);
                    outs++;
                    if (e.last) fin = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (stop_after >= 0 && idx == stop_after) return;
        end
        in_valid = 1'b0;
        start = 1'b0;
        chk("frame_complete", fin, 1);
        chk("frame_outs", outs, len);
        if (fin) begin
            @(negedge clk);
            chk("done_pulse", done, 1);
            chk("busy_after", busy, 0);
            chk("in_ready_idle", in_ready, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("done_single", done, 0);
            chk("sb_empty", 32'(sb.size()), 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_rom_en"}, rom_en, 0);
        chk({tag, "_addr_a"}, rom_addr_a, 0);
        chk({tag, "_addr_b"}, rom_addr_b, 0);
    endtask

    initial begin
        for (int k = 0; k < 96; k++) lut[k] = 16'(816 + k * 330);
        lut[0]  = 16'h0330;
        lut[1]  = 16'h0661;
        lut[2]  = 16'h098F;
        lut[95] = 16'h7FFD;

        #1 rst_n = 1'b0;
        #2;
        in_valid = 1'b1;
        in_data = 16'h1234;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-sample frames against the reference values
        xs[0] = 16'h0000; run_frame(1, 0, 1'b1, -1, -1, 1'b1, 16'h0000);
        xs[0] = 16'h0180; run_frame(1, 0, 1'b1, -1, -1, 1'b1, 16'h0017);
        xs[0] = 16'h5F00; run_frame(1, 0, 1'b1, -1, -1, 1'b1, 16'h5EFD);
        xs[0] = 16'hFFFF; run_frame(1, 0, 1'b1, -1, -1, 1'b1, 16'h0000);

        // Eight back-to-back samples, toggling backpressure, stray start mid-frame
        xs[0] = 16'h0000; xs[1] = 16'h0180; xs[2] = 16'h5EFF; xs[3] = 16'h5F00;
        xs[4] = 16'h7FFF; xs[5] = 16'h8000; xs[6] = 16'h1234; xs[7] = 16'h00FF;
        run_frame(8, 1, 1'b0, 4, -1, 1'b0, 16'h0000);

        // Random data and random backpressure
        for (int k = 0; k < 16; k++) xs[k] = 16'($urandom_range(0, 16'hFFFF));
        run_frame(8, 2, 1'b0, -1, -1, 1'b0, 16'h0000);

        // Zero-length frame
        cfg_len = '0;
        start = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_len_done", done, 1);
        chk("zero_len_busy", busy, 0);
        chk("zero_len_in_ready", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_len_done_single", done, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Reset after 3 of 8 samples have been accepted
        run_frame(8, 0, 1'b0, -1, 3, 1'b0, 16'h0000);
        chk("pre_reset_out_valid", out_valid, 1);
        chk("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        sb.delete();
        in_data = 16'h0180;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_in_ready", in_ready, 0);
            chk("post_reset_out_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        xs[0] = 16'h0180; xs[1] = 16'h2345;
        run_frame(2, 0, 1'b1, -1, -1, 1'b0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
